// File: rtl/wishbone_master.sv
// Wishbone B4 pipelined master: turns one valid/ready request into a single bus cycle
// and returns a one-cycle response, aborting with an error if no ack arrives in time.
module wishbone_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    input  logic [31:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {StIdle, StRequest, StWaitAck} state_t;

    state_t      state, state_next;
    logic [31:0] count, count_next;
    logic        cyc_next, stb_next, we_next;
    logic [31:0] adr_next, dat_next;
    logic [3:0]  sel_next;
    logic        rsp_valid_next, rsp_err_next;
    logic [31:0] rsp_data_next;
    logic        ack_taken, expire;

    assign req_ready_o = (state == StIdle);

    // An ack that arrives while the strobe is still stalled is not a valid handshake.
    assign ack_taken = wb_ack_i &&
                       ((state == StWaitAck) || (state == StRequest && !wb_stall_i));
    assign expire    = (TIMEOUT_CYCLES != 0) && (count + 32'd1 == TIMEOUT_CYCLES);

    always_comb begin
        state_next     = state;
        count_next     = count;
        cyc_next       = wb_cyc_o;
        stb_next       = wb_stb_o;
        we_next        = wb_we_o;
        adr_next       = wb_adr_o;
        dat_next       = wb_dat_o;
        sel_next       = wb_sel_o;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_data_next  = 32'd0;

        case (state)
            StIdle: begin
                if (req_valid_i) begin
                    adr_next   = req_addr_i;
                    we_next    = req_we_i;
                    sel_next   = req_sel_i;
                    dat_next   = req_data_i;
                    cyc_next   = 1'b1;
                    stb_next   = 1'b1;
                    count_next = 32'd0;
                    state_next = StRequest;
                end
            end
            StRequest, StWaitAck: begin
                count_next = count + 32'd1;
                if (ack_taken) begin
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = wb_we_o ? 32'd0 : wb_dat_i;
                    state_next     = StIdle;
                end else if (expire) begin
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    state_next     = StIdle;
                end else if (state == StRequest && !wb_stall_i) begin
                    stb_next   = 1'b0;
                    state_next = StWaitAck;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= StIdle;
            count       <= 32'd0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= 32'd0;
            wb_dat_o    <= 32'd0;
            wb_sel_o    <= 4'd0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= 32'd0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            wb_cyc_o    <= cyc_next;
            wb_stb_o    <= stb_next;
            wb_we_o     <= we_next;
            wb_adr_o    <= adr_next;
            wb_dat_o    <= dat_next;
            wb_sel_o    <= sel_next;
            rsp_valid_o <= rsp_valid_next;
            rsp_err_o   <= rsp_err_next;
            rsp_data_o  <= rsp_data_next;
        end
    end

endmodule

// File: tb/tb_wishbone_master.sv
// Self-checking bench for wishbone_master: directed plan cases plus random transfers,
// each checked cycle by cycle against a timing model derived from stall/ack arithmetic.
module tb_wishbone_master;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic        wb_we, wb_stb, wb_ack, wb_cyc, wb_stall;
    logic [3:0]  wb_sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdat;
        int          s;     // stalled strobe cycles
        int          d;     // cycles from strobe end to ack
        bit          hold;  // keep req_valid high for the next entry
    } txn_t;

    txn_t q[$];

    wishbone_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_we_i(req_we), .req_sel_i(req_sel), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we),
        .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack), .wb_cyc_o(wb_cyc),
        .wb_stall_i(wb_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [31:0] rdat,
                                input int s, input int d, input bit hold);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.rdat = rdat;
        t.s = s; t.d = d; t.hold = hold;
        return t;
    endfunction

    task automatic drive_req(input txn_t t);
        req_valid = 1'b1;
        req_we    = t.we;
        req_addr  = t.adr;
        req_data  = t.dat;
        req_sel   = t.sel;
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            req_valid = 1'b0;
            wb_stall  = 1'b0;
            wb_ack    = 1'($urandom_range(0, 1));
            wb_dat_i  = $urandom;
            @(negedge clk);
            check("idle_cyc", wb_cyc, 0);
            check("idle_stb", wb_stb, 0);
            check("idle_rsp", rsp_valid, 0);
            check("idle_ready", req_ready, 1);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the response cycle.
    task automatic run_txn(input int i);
        txn_t        t;
        bit          err;
        int          end_k;
        logic [31:0] exp_data;
        t = q[i];
        // Response arrives one cycle after the ack, or one cycle after T unacked cycles.
        err      = (t.s + t.d + 1) > T;
        end_k    = err ? T + 1 : t.s + t.d + 2;
        exp_data = (err || t.we) ? 32'd0 : t.rdat;
        check("accept_ready", req_ready, 1);
        drive_req(t);
        wb_stall = 1'b0;
        wb_ack   = 1'($urandom_range(0, 1));
        wb_dat_i = $urandom;
        for (int k = 1; k <= end_k; k++) begin
            @(negedge clk);
            if (k < end_k) begin
                check("busy_cyc", wb_cyc, 1);
                check("busy_stb", wb_stb, (k <= t.s + 1) ? 1 : 0);
                check("busy_ready", req_ready, 0);
                check("busy_rsp", rsp_valid, 0);
                check("busy_adr", wb_adr, t.adr);
                check("busy_we", wb_we, t.we);
                check("busy_sel", wb_sel, t.sel);
                check("busy_dat", wb_dat_o, t.dat);
                wb_stall = (k <= t.s);
                wb_ack   = (k == t.s + 1 + t.d);
                wb_dat_i = wb_ack ? t.rdat : $urandom;
                if (t.hold && i + 1 < q.size()) drive_req(q[i + 1]);
                else req_valid = 1'b0;
            end else begin
                check("done_cyc", wb_cyc, 0);
                check("done_stb", wb_stb, 0);
                check("done_rsp", rsp_valid, 1);
                check("done_err", rsp_err, err);
                check("done_data", rsp_data, exp_data);
                check("done_ready", req_ready, 1);
                wb_stall  = 1'b0;
                wb_ack    = 1'b0;
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic run_queue();
        for (int i = 0; i < q.size(); i++) begin
            run_txn(i);
            if (!q[i].hold) idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_sel = '0;
        wb_dat_i = '0; wb_ack = 1'b0; wb_stall = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_err", rsp_err, 0);
        check("rst_rdata", rsp_data, 0);
        check("rst_adr", wb_adr, 0);
        check("rst_wdat", wb_dat_o, 0);
        check("rst_we", wb_we, 0);
        check("rst_sel", wb_sel, 0);
        rst = 1'b0;
        idle_cycles(2);

        q.push_back(mk(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1, 1'b0));
        q.push_back(mk(1'b0, 32'h104, 32'h0, 4'hF, 32'hCAFEF00D, 3, 1, 1'b0));
        q.push_back(mk(1'b1, 32'h200, 32'h12345678, 4'hC, 32'hFFFFFFFF, 0, 1, 1'b0));
        q.push_back(mk(1'b0, 32'h300, 32'h0, 4'hF, 32'h11111111, 0, 1, 1'b1));
        q.push_back(mk(1'b0, 32'h304, 32'h0, 4'hF, 32'h22222222, 0, 0, 1'b0));
        q.push_back(mk(1'b0, 32'h400, 32'h0, 4'hF, 32'h33333333, 0, 100, 1'b0));
        q.push_back(mk(1'b0, 32'h404, 32'h0, 4'h3, 32'h44444444, 1, 2, 1'b0));
        run_queue();

        // Reset while waiting for the ack.
        idle_cycles(1);
        drive_req(mk(1'b0, 32'h500, 32'h0, 4'hF, 32'h0, 0, 0, 1'b0));
        wb_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_cyc", wb_cyc, 1);
        check("pre_rst_stb", wb_stb, 0);
        rst = 1'b1;
        #1;
        check("async_rst_cyc", wb_cyc, 0);
        check("async_rst_stb", wb_stb, 0);
        check("async_rst_rsp", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        wb_ack = 1'b1;
        wb_dat_i = 32'hBAD0BAD0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("post_rst_rsp", rsp_valid, 0);
            check("post_rst_ready", req_ready, 1);
            check("post_rst_cyc", wb_cyc, 0);
            wb_ack = 1'b0;
        end

        q.delete();
        for (int i = 0; i < 40; i++) begin
            q.push_back(mk(1'($urandom_range(0, 1)), $urandom, $urandom,
                           4'($urandom_range(0, 15)), $urandom,
                           $urandom_range(0, 3), $urandom_range(0, 4),
                           $urandom_range(0, 3) == 0));
        end
        run_queue();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
